// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding, mode numbering and
// the CPOL/CPHA decode used by the master and its clock generator.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_XFER,
        ST_CS_HOLD,
        ST_CS_GAP
    } spi_state_e;

    localparam int SPI_MODE_0 = 0;
    localparam int SPI_MODE_1 = 1;
    localparam int SPI_MODE_2 = 2;
    localparam int SPI_MODE_3 = 3;

    localparam int EDGES_PER_BYTE = 16;

    typedef logic [4:0] edge_cnt_t;

    function automatic logic spi_cpol(input int mode);
        return (mode == SPI_MODE_2) || (mode == SPI_MODE_3);
    endfunction

    function automatic logic spi_cpha(input int mode);
        return (mode == SPI_MODE_1) || (mode == SPI_MODE_3);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// SCLK generator: while enabled, toggles SCLK every CLKS_PER_HALF_BIT cycles and
// flags each toggle as leading or trailing; parks SCLK at CPOL when disabled.
module spi_master_clkgen
    import spi_pkg::*;
#(
    parameter bit CPOL              = 1'b0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_en,
    output logic      o_tick,
    output logic      o_lead,
    output logic      o_trail,
    output logic      o_sclk,
    output edge_cnt_t o_edge_cnt
);

    localparam int            HW        = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);

    logic [HW-1:0] half_cnt_q, half_cnt_d;
    edge_cnt_t     edge_cnt_q, edge_cnt_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    // Strobes are combinational so the master acts on the same clock edge
    // that moves SCLK; edge_cnt_q is the number of edges already made.
    always_comb begin
        tick       = i_en && (half_cnt_q == HALF_LAST);
        half_cnt_d = half_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        if (!i_en) begin
            half_cnt_d = '0;
            edge_cnt_d = '0;
            sclk_d     = CPOL;
        end else if (tick) begin
            half_cnt_d = '0;
            edge_cnt_d = edge_cnt_q + 1'b1;
            sclk_d     = ~sclk_q;
        end else begin
            half_cnt_d = half_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            half_cnt_q <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= CPOL;
        end else begin
            half_cnt_q <= half_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
        end
    end

    assign o_tick     = tick;
    assign o_lead     = tick && !edge_cnt_q[0];
    assign o_trail    = tick && edge_cnt_q[0];
    assign o_sclk     = sclk_q;
    assign o_edge_cnt = edge_cnt_q;

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master, modes 0-3. Defining SPI_MASTER_BURST_EN keeps CS low
// for BURST_WAIT_CLKS cycles after each byte so a follow-on byte skips setup.
module spi_master
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 3,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_SETUP_CLKS     = 2,
    parameter int CS_GAP_CLKS       = 2,
    parameter int BURST_WAIT_CLKS   = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    output logic       o_SPI_MOSI,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_CS_n
);

    localparam bit CPOL  = spi_cpol(SPI_MODE);
    localparam bit CPHA  = spi_cpha(SPI_MODE);
    localparam int CNT_W = $clog2(max3(CS_SETUP_CLKS, CS_GAP_CLKS, BURST_WAIT_CLKS) + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP_CLKS - 1);
`ifdef SPI_MASTER_BURST_EN
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(BURST_WAIT_CLKS - 1);
`endif
    localparam edge_cnt_t LAST_EDGE_IDX = edge_cnt_t'(EDGES_PER_BYTE - 1);

    spi_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             ready_q, ready_d;
    logic             rx_pend_q, rx_pend_d;
    logic             rx_dv_q, rx_dv_d;

    logic      xfer_en, tick, lead, trail, sclk;
    edge_cnt_t edge_cnt;
    logic      last_edge, launch, sample, accept;

    assign xfer_en = (state_q == ST_XFER);

    spi_master_clkgen #(
        .CPOL             (CPOL),
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_clkgen (
        .i_clk     (i_Clk),
        .i_rst     (i_Rst),
        .i_en      (xfer_en),
        .o_tick    (tick),
        .o_lead    (lead),
        .o_trail   (trail),
        .o_sclk    (sclk),
        .o_edge_cnt(edge_cnt)
    );

    // CPHA=0 already put bit7 out at CS fall, so its 8th trailing edge has nothing to launch.
    assign last_edge = tick && (edge_cnt == LAST_EDGE_IDX);
    assign launch    = CPHA ? lead : (trail && (edge_cnt != LAST_EDGE_IDX));
    assign sample    = CPHA ? trail : lead;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        mosi_d    = mosi_q;
        rx_pend_d = 1'b0;
        rx_dv_d   = rx_pend_q;
        rx_byte_d = rx_pend_q ? rx_q : rx_byte_q;
        accept    = 1'b0;

        if (sample) rx_d = {rx_q[6:0], i_SPI_MISO};
        if (launch) begin
            mosi_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
        end

        case (state_q)
            ST_IDLE: begin
                if (i_TX_DV) begin
                    accept  = 1'b1;
                    state_d = ST_CS_SETUP;
                    cnt_d   = '0;
                end
            end
            ST_CS_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_XFER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (last_edge) begin
                    rx_pend_d = 1'b1;
                    cnt_d     = '0;
`ifdef SPI_MASTER_BURST_EN
                    state_d   = ST_CS_HOLD;
`else
                    state_d   = ST_CS_GAP;
`endif
                end
            end
`ifdef SPI_MASTER_BURST_EN
            ST_CS_HOLD: begin
                if (i_TX_DV) begin
                    accept  = 1'b1;
                    state_d = ST_XFER;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_CS_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_CS_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            if (!CPHA) begin
                mosi_d = i_TX_Byte[7];
                tx_d   = {i_TX_Byte[6:0], 1'b0};
            end else begin
                tx_d = i_TX_Byte;
            end
        end

        cs_n_d  = (state_d == ST_IDLE) || (state_d == ST_CS_GAP);
        ready_d = (state_d == ST_IDLE) || (state_d == ST_CS_HOLD);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_byte_q <= '0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            ready_q   <= 1'b1;
            rx_pend_q <= 1'b0;
            rx_dv_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_byte_q <= rx_byte_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            ready_q   <= ready_d;
            rx_pend_q <= rx_pend_d;
            rx_dv_q   <= rx_dv_d;
        end
    end

    assign o_TX_Ready = ready_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_SPI_Clk  = sclk;
    assign o_SPI_MOSI = mosi_q;
    assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench: one spi_master per SPI mode, observed on the falling clock
// edge by a cycle-based slave model (loopback or canned response).
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tx_dv = '0;
    logic [3:0] tx_ready, rx_dv, sclk, mosi, miso, cs_n;
    logic [7:0] tx_byte [4];
    logic [7:0] rx_byte [4];
    logic [3:0] loop_mask = '0;
    logic [3:0] slv_out = '0;

    assign miso = (loop_mask & mosi) | (~loop_mask & slv_out);

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_master #(.SPI_MODE(m)) u_dut (
            .i_Clk     (clk),
            .i_Rst     (rst),
            .i_TX_DV   (tx_dv[m]),
            .i_TX_Byte (tx_byte[m]),
            .o_TX_Ready(tx_ready[m]),
            .o_RX_DV   (rx_dv[m]),
            .o_RX_Byte (rx_byte[m]),
            .o_SPI_Clk (sclk[m]),
            .o_SPI_MOSI(mosi[m]),
            .i_SPI_MISO(miso[m]),
            .o_SPI_CS_n(cs_n[m])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    int         edges, dv_cnt, bad, cs_rise, gap_cur, gap_min, slv_idx;
    logic [7:0] dv_byte, slv_rx, slv_resp;
    logic       p_sclk, p_mosi, p_cs, p_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mon_reset(input int m);
        edges = 0; dv_cnt = 0; bad = 0; cs_rise = 0;
        gap_cur = 0; gap_min = 999; slv_idx = -1;
        slv_rx = '0; dv_byte = '0;
        p_sclk = sclk[m]; p_mosi = mosi[m]; p_cs = cs_n[m]; p_ready = tx_ready[m];
    endtask

    // One clock of slave/monitor activity; SPI edges are seen as changes since last cycle.
    task automatic step(input int m);
        logic cpol, cpha, ed, lead, launch, samp;
        @(negedge clk);
        cpol   = (m >= 2);
        cpha   = ((m % 2) == 1);
        ed     = (sclk[m] != p_sclk);
        lead   = ed && (p_sclk == cpol);
        launch = ed && (cpha ? lead : !lead);
        samp   = ed && (cpha ? !lead : lead);
        if (ed) edges++;
        if (samp) begin
            slv_rx = {slv_rx[6:0], mosi[m]};
            if (mosi[m] != p_mosi) bad++;
        end else if ((mosi[m] != p_mosi) && !launch && !p_ready) begin
            bad++;
        end
        if (rx_dv[m]) begin
            dv_cnt++;
            dv_byte = rx_byte[m];
        end
        if (!cs_n[m] && p_cs) begin
            if ((cs_rise > 0) && (gap_cur < gap_min)) gap_min = gap_cur;
            gap_cur = 0;
            slv_idx = 7;
            if (!cpha) begin
                slv_out[m] = slv_resp[slv_idx];
                slv_idx--;
            end
        end else if (launch && (slv_idx >= 0)) begin
            slv_out[m] = slv_resp[slv_idx];
            slv_idx--;
        end
        if (cs_n[m] && !p_cs) begin
            cs_rise++;
            gap_cur = 0;
        end
        if (cs_n[m]) gap_cur++;
        p_sclk = sclk[m]; p_mosi = mosi[m]; p_cs = cs_n[m]; p_ready = tx_ready[m];
    endtask

    task automatic send(input int m, input logic [7:0] b);
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        step(m);
        tx_dv[m]   = 1'b0;
    endtask

    task automatic wait_dv(input int m, input int n0, output int lat);
        lat = 0;
        while ((dv_cnt == n0) && (lat < 200)) begin
            step(m);
            lat++;
        end
        if (dv_cnt == n0) lat = -1;
    endtask

    task automatic xfer(input int m, input logic [7:0] b, input logic [7:0] resp,
                        input logic loop, output int lat);
        mon_reset(m);
        loop_mask[m] = loop;
        slv_resp     = resp;
        send(m, b);
        wait_dv(m, 0, lat);
        repeat (8) step(m);
    endtask

    task automatic rst_mid(input int m, input int n);
        int k;
        mon_reset(m);
        loop_mask[m] = 1'b1;
        send(m, 8'h5A);
        k = 0;
        while ((edges < n) && (k < 100)) begin
            step(m);
            k++;
        end
        chk("rmid_edges", edges, n);
        rst = 1'b1;
        step(m);
        rst = 1'b0;
        chk("rmid_cs_n", cs_n[m], 1);
        chk("rmid_sclk", sclk[m], (m >= 2));
        chk("rmid_ready", tx_ready[m], 1);
        chk("rmid_no_dv", dv_cnt, 0);
        repeat (40) step(m);
        chk("rmid_no_dv_late", dv_cnt, 0);
        chk("rmid_rx_byte", rx_byte[m], 0);
    endtask

    int         lat, k;
    logic [7:0] first;
    int         vm  [4] = '{1, 1, 2, 2};
    logic [7:0] vtx [4] = '{8'h80, 8'h01, 8'h80, 8'h01};
    logic [7:0] vrs [4] = '{8'h01, 8'h80, 8'h7E, 8'hE7};
`ifdef SPI_MASTER_BURST_EN
    int lat2_exp = 33;
`else
    int lat2_exp = 35;
`endif

    initial begin
        for (int i = 0; i < 4; i++) tx_byte[i] = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_sclk", sclk, 4'b1100);
        chk("rst_mosi", mosi, 4'h0);
        chk("rst_rx_dv", rx_dv, 4'h0);
        chk("rst_ready", tx_ready, 4'hF);
        chk("rst_rx_byte", rx_byte[3], 8'h00);
        rst = 1'b0;

        // mode 3 loopback
        xfer(3, 8'hA5, 8'h00, 1'b1, lat);
        chk("m3_lat", lat, 35);
        chk("m3_edges", edges, 16);
        chk("m3_rx", dv_byte, 8'hA5);
        chk("m3_dv_cnt", dv_cnt, 1);
        chk("m3_sclk_idle", sclk[3], 1);
        chk("m3_rx_hold", rx_byte[3], 8'hA5);
        chk("m3_mosi_stable", bad, 0);

        // mode 0 against a slave answering 0xC3
        xfer(0, 8'h3C, 8'hC3, 1'b0, lat);
        chk("m0_lat", lat, 35);
        chk("m0_slave_rx", slv_rx, 8'h3C);
        chk("m0_rx", dv_byte, 8'hC3);
        chk("m0_edges", edges, 16);
        chk("m0_sclk_idle", sclk[0], 0);
        chk("m0_mosi_stable", bad, 0);

        // modes 1 and 2, single-bit patterns
        for (int i = 0; i < 4; i++) begin
            xfer(vm[i], vtx[i], vrs[i], 1'b0, lat);
            chk("m12_slave_rx", slv_rx, vtx[i]);
            chk("m12_rx", dv_byte, vrs[i]);
            chk("m12_mosi_stable", bad, 0);
            chk("m12_mosi_hold", mosi[vm[i]], vtx[i][0]);
            chk("m12_sclk_idle", sclk[vm[i]], (vm[i] >= 2));
            chk("m12_lat", lat, 35);
        end

        // i_TX_DV while busy is dropped
        mon_reset(3);
        loop_mask[3] = 1'b1;
        send(3, 8'h01);
        repeat (10) step(3);
        tx_byte[3] = 8'hFF;
        tx_dv[3]   = 1'b1;
        step(3);
        tx_dv[3]   = 1'b0;
        wait_dv(3, 0, lat);
        repeat (12) step(3);
        chk("busy_rx", dv_byte, 8'h01);
        chk("busy_slave_rx", slv_rx, 8'h01);
        chk("busy_dv_cnt", dv_cnt, 1);
        chk("busy_edges", edges, 16);
        chk("busy_cs_n", cs_n[3], 1);

        rst_mid(3, 8);
        rst_mid(1, 7);

        // back-to-back bytes: burst keeps CS low, otherwise a CS gap appears
        mon_reset(3);
        loop_mask[3] = 1'b1;
        send(3, 8'h12);
        wait_dv(3, 0, lat);
        first = dv_byte;
        k = 0;
        while (!tx_ready[3] && (k < 20)) begin
            step(3);
            k++;
        end
        send(3, 8'h34);
        wait_dv(3, 1, lat);
        chk("b2b_first", first, 8'h12);
        chk("b2b_second", dv_byte, 8'h34);
        chk("b2b_edges", edges, 32);
        chk("b2b_dv_cnt", dv_cnt, 2);
        chk("b2b_lat2", lat, lat2_exp);
`ifdef SPI_MASTER_BURST_EN
        chk("b2b_cs_low", cs_rise, 0);
`else
        chk("b2b_cs_rises", cs_rise, 2);
        chk("b2b_gap_min", (gap_min >= 2), 1);
`endif
        repeat (12) step(3);
        chk("b2b_end_cs_n", cs_n[3], 1);
        chk("b2b_end_ready", tx_ready[3], 1);
        chk("b2b_end_dv_cnt", dv_cnt, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog no_finish");
        $fatal(1, "watchdog");
    end

endmodule
